// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// Converts one register command at a time into an AXI-Lite write or read
// transaction and returns a one-cycle response strobe. A watchdog bounds
// each transaction; on expiry the response carries RSP_TIMEOUT = 1.
module axi_lite_master #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              AXI_M_ACLK,
  input  logic              AXI_M_ARESET,

  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [31:0]       CMD_WDATA,
  input  logic [3:0]        CMD_WSTRB,

  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic [1:0]        RSP_RESP,
  output logic              RSP_TIMEOUT,

  output logic [ADDR_W-1:0] AXI_M_AWADDR,
  output logic [2:0]        AXI_M_AWPROT,
  output logic              AXI_M_AWVALID,
  input  logic              AXI_M_AWREADY,

  output logic [31:0]       AXI_M_WDATA,
  output logic [3:0]        AXI_M_WSTRB,
  output logic              AXI_M_WVALID,
  input  logic              AXI_M_WREADY,

  input  logic [1:0]        AXI_M_BRESP,
  input  logic              AXI_M_BVALID,
  output logic              AXI_M_BREADY,

  output logic [ADDR_W-1:0] AXI_M_ARADDR,
  output logic [2:0]        AXI_M_ARPROT,
  output logic              AXI_M_ARVALID,
  input  logic              AXI_M_ARREADY,

  input  logic [31:0]       AXI_M_RDATA,
  input  logic [1:0]        AXI_M_RRESP,
  input  logic              AXI_M_RVALID,
  output logic              AXI_M_RREADY
);

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
  localparam int unsigned      CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [1:0]       RESP_TO = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_resp_q, rsp_resp_d;
  logic               rsp_timeout_q, rsp_timeout_d;

  logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic               wd_expire;
  logic               fire_to;

  assign aw_hs = awvalid_q & AXI_M_AWREADY;
  assign w_hs  = wvalid_q  & AXI_M_WREADY;
  assign b_hs  = bready_q  & AXI_M_BVALID;
  assign ar_hs = arvalid_q & AXI_M_ARREADY;
  assign r_hs  = rready_q  & AXI_M_RVALID;

  // Saturating increment; expiry is judged on the value this cycle brings the count to.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign wd_expire = (TIMEOUT != 32'd0) && (cnt_inc == CNT_MAX);

  // Next-state, command capture, response capture and registered-output values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    fire_to       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          addr_d    = CMD_ADDR;
          wdata_d   = CMD_WDATA;
          wstrb_d   = CMD_WSTRB;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = CMD_WRITE ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        cnt_d     = cnt_inc;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = S_WRESP;
        end else if (wd_expire) begin
          fire_to = 1'b1;
        end
      end
      S_WRESP: begin
        cnt_d = cnt_inc;
        if (b_hs) begin
          rsp_rdata_d   = '0;
          rsp_resp_d    = AXI_M_BRESP;
          rsp_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else if (wd_expire) begin
          fire_to = 1'b1;
        end
      end
      S_RADDR: begin
        cnt_d = cnt_inc;
        if (ar_hs) begin
          state_d = S_RDATA;
        end else if (wd_expire) begin
          fire_to = 1'b1;
        end
      end
      S_RDATA: begin
        cnt_d = cnt_inc;
        if (r_hs) begin
          rsp_rdata_d   = AXI_M_RDATA;
          rsp_resp_d    = AXI_M_RRESP;
          rsp_timeout_d = 1'b0;
          state_d       = S_DONE;
        end else if (wd_expire) begin
          fire_to = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog abort: every handshake signal drops as DONE is entered.
    if (fire_to) begin
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_TO;
      rsp_timeout_d = 1'b1;
      state_d       = S_DONE;
    end

    cmd_ready_d = (state_d == S_IDLE);
    awvalid_d   = (state_d == S_WADDR) && !aw_done_d;
    wvalid_d    = (state_d == S_WADDR) && !w_done_d;
    bready_d    = (state_d == S_WRESP);
    arvalid_d   = (state_d == S_RADDR);
    rready_d    = (state_d == S_RDATA);
    rsp_valid_d = (state_d == S_DONE);
  end

  // State, command and output registers; reset discards any in-flight transaction.
  always_ff @(posedge AXI_M_ACLK or posedge AXI_M_ARESET) begin
    if (AXI_M_ARESET) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign RSP_TIMEOUT   = rsp_timeout_q;

  assign AXI_M_AWADDR  = addr_q;
  assign AXI_M_AWPROT  = 3'b000;
  assign AXI_M_AWVALID = awvalid_q;
  assign AXI_M_WDATA   = wdata_q;
  assign AXI_M_WSTRB   = wstrb_q;
  assign AXI_M_WVALID  = wvalid_q;
  assign AXI_M_BREADY  = bready_q;
  assign AXI_M_ARADDR  = addr_q;
  assign AXI_M_ARPROT  = 3'b000;
  assign AXI_M_ARVALID = arvalid_q;
  assign AXI_M_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: programmable-latency AXI-Lite slave model,
// scoreboard of expected responses, and a decoupled response monitor.
module tb_axi_lite_master;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TO     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [3:0]        cmd_wstrb = '0;
  logic              CMD_READY, RSP_VALID, RSP_TIMEOUT;
  logic [31:0]       RSP_RDATA;
  logic [1:0]        RSP_RESP;

  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [2:0]        AWPROT, ARPROT;
  logic              AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic              ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]        BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0]       RDATA = '0;

  axi_lite_master #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .AXI_M_ACLK   (clk),
    .AXI_M_ARESET (rst),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (CMD_READY),
    .CMD_WRITE    (cmd_write),
    .CMD_ADDR     (cmd_addr),
    .CMD_WDATA    (cmd_wdata),
    .CMD_WSTRB    (cmd_wstrb),
    .RSP_VALID    (RSP_VALID),
    .RSP_RDATA    (RSP_RDATA),
    .RSP_RESP     (RSP_RESP),
    .RSP_TIMEOUT  (RSP_TIMEOUT),
    .AXI_M_AWADDR (AWADDR),
    .AXI_M_AWPROT (AWPROT),
    .AXI_M_AWVALID(AWVALID),
    .AXI_M_AWREADY(AWREADY),
    .AXI_M_WDATA  (WDATA),
    .AXI_M_WSTRB  (WSTRB),
    .AXI_M_WVALID (WVALID),
    .AXI_M_WREADY (WREADY),
    .AXI_M_BRESP  (BRESP),
    .AXI_M_BVALID (BVALID),
    .AXI_M_BREADY (BREADY),
    .AXI_M_ARADDR (ARADDR),
    .AXI_M_ARPROT (ARPROT),
    .AXI_M_ARVALID(ARVALID),
    .AXI_M_ARREADY(ARREADY),
    .AXI_M_RDATA  (RDATA),
    .AXI_M_RRESP  (RRESP),
    .AXI_M_RVALID (RVALID),
    .AXI_M_RREADY (RREADY)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Slave configuration, owned by the main sequence.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  bit          slave_rst  = 1'b0;
  bit          allow_drop = 1'b0;

  // Handshake observer: records what crossed each channel at every edge.
  logic              aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
  int                aw_n = 0, w_n = 0, b_n = 0;
  logic [ADDR_W-1:0] aw_addr_seen = '0, ar_addr_seen = '0;
  logic [31:0]       w_data_seen = '0;
  logic [3:0]        w_strb_seen = '0;

  always @(posedge clk) begin
    aw_hs <= AWVALID && AWREADY;
    w_hs  <= WVALID && WREADY;
    b_hs  <= BVALID && BREADY;
    ar_hs <= ARVALID && ARREADY;
    r_hs  <= RVALID && RREADY;
    if (AWVALID && AWREADY) begin aw_n <= aw_n + 1; aw_addr_seen <= AWADDR; end
    if (WVALID && WREADY)   begin w_n <= w_n + 1; w_data_seen <= WDATA; w_strb_seen <= WSTRB; end
    if (BVALID && BREADY)   b_n <= b_n + 1;
    if (ARVALID && ARREADY) ar_addr_seen <= ARADDR;
  end

  // Pending VALIDs must stay high with stable payload until their handshake.
  logic              aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [ADDR_W-1:0] aw_prev = '0, ar_prev = '0;
  logic [31:0]       w_prev = '0;
  logic [3:0]        ws_prev = '0;
  int                stab_err = 0;

  always @(posedge clk) begin
    if (!rst && !allow_drop &&
        ((aw_pend && (!AWVALID || AWADDR != aw_prev)) ||
         (w_pend  && (!WVALID || WDATA != w_prev || WSTRB != ws_prev)) ||
         (ar_pend && (!ARVALID || ARADDR != ar_prev))))
      stab_err <= stab_err + 1;
    aw_pend <= AWVALID && !AWREADY;
    w_pend  <= WVALID && !WREADY;
    ar_pend <= ARVALID && !ARREADY;
    aw_prev <= AWADDR;
    ar_prev <= ARADDR;
    w_prev  <= WDATA;
    ws_prev <= WSTRB;
  end

  // Slave model, driven mid-cycle.
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (slave_rst) begin
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 1'b0; w_got = 1'b0; r_pend = 1'b0;
      end else begin
        if (aw_hs) begin AWREADY = 1'b0; aw_cnt = 0; aw_got = 1'b1; end
        else if (AWVALID && !AWREADY) begin
          if (aw_cnt >= aw_dly) AWREADY = 1'b1; else aw_cnt++;
        end else if (!AWVALID) aw_cnt = 0;

        if (w_hs) begin WREADY = 1'b0; w_cnt = 0; w_got = 1'b1; end
        else if (WVALID && !WREADY) begin
          if (w_cnt >= w_dly) WREADY = 1'b1; else w_cnt++;
        end else if (!WVALID) w_cnt = 0;

        if (b_hs) begin BVALID = 1'b0; BRESP = 2'b00; end
        else if (aw_got && w_got && !BVALID) begin
          if (b_cnt >= b_dly) begin
            BVALID = 1'b1; BRESP = cfg_bresp; aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
          end else b_cnt++;
        end

        if (ar_hs) begin ARREADY = 1'b0; ar_cnt = 0; r_pend = 1'b1; end
        else if (ARVALID && !ARREADY) begin
          if (ar_cnt >= ar_dly) ARREADY = 1'b1; else ar_cnt++;
        end else if (!ARVALID) ar_cnt = 0;

        if (r_hs) begin RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; end
        else if (r_pend && !RVALID) begin
          if (r_cnt >= r_dly) begin
            RVALID = 1'b1; RDATA = cfg_rdata; RRESP = cfg_rresp; r_pend = 1'b0; r_cnt = 0;
          end else r_cnt++;
        end
      end
    end
  end

  // Response monitor: pops the oldest expectation on every response strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (RSP_VALID) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(RSP_VALID), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata",   RSP_RDATA, e.rdata);
          check("rsp_resp",    32'(RSP_RESP), 32'(e.resp));
          check("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e.to));
          check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  // Presents one command in cycle 0; returns at the negedge of cycle 1.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit push, input logic [31:0] erd,
                       input logic [1:0] ersp, input logic eto, input int elat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!CMD_READY && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_at_issue", 32'(CMD_READY), 32'h1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    if (push) begin
      e.rdata = erd; e.resp = ersp; e.to = eto; e.acc = cyc; e.lat = elat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("response_arrived", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int aw0, w0, b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(CMD_READY), 32'h0);
    check("rst_ctl", 32'({RSP_VALID, AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", 32'(CMD_READY), 32'h1);

    // Zero-wait write
    issue(1'b1, 4'h0, 32'h0000_0001, 4'hF, 1'b1, 32'h0, 2'b00, 1'b0, 3);
    @(negedge clk);
    @(negedge clk);
    check("t1_cmd_ready_c3", 32'(CMD_READY), 32'h0);
    @(negedge clk);
    check("t1_cmd_ready_c4", 32'(CMD_READY), 32'h1);
    wait_done();
    check("t1_awaddr", 32'(aw_addr_seen), 32'h0);
    check("t1_wdata", w_data_seen, 32'h0000_0001);
    check("t1_wstrb", 32'(w_strb_seen), 32'hF);

    // Read with three AR wait cycles
    ar_dly = 3; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
    issue(1'b0, 4'h4, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 6);
    wait_done();
    check("t2_araddr", 32'(ar_addr_seen), 32'h4);
    ar_dly = 0;

    // W handshakes two cycles before AW; DECERR write response
    aw_dly = 2; w_dly = 0; cfg_bresp = 2'b11;
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    issue(1'b1, 4'h8, 32'hA5A5_5A5A, 4'h3, 1'b1, 32'h0, 2'b11, 1'b0, 5);
    @(negedge clk);
    check("t3_wvalid_c2", 32'(WVALID), 32'h0);
    check("t3_awvalid_c2", 32'(AWVALID), 32'h1);
    wait_done();
    check("t3_aw_count", 32'(aw_n - aw0), 32'h1);
    check("t3_w_count", 32'(w_n - w0), 32'h1);
    check("t3_b_count", 32'(b_n - b0), 32'h1);
    check("t3_awaddr", 32'(aw_addr_seen), 32'h8);
    check("t3_wdata", w_data_seen, 32'hA5A5_5A5A);
    check("t3_wstrb", 32'(w_strb_seen), 32'h3);
    aw_dly = 0; cfg_bresp = 2'b00;

    // Read returning SLVERR
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
    issue(1'b0, 4'hC, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 2'b10, 1'b0, 3);
    wait_done();
    cfg_rresp = 2'b00;

    // R handshake on the very edge the watchdog reaches its limit
    ar_dly = 6; cfg_rdata = 32'hCAFE_F00D;
    issue(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 2'b00, 1'b0, 9);
    wait_done();

    // Slave never accepts the read address
    ar_dly = 1000; allow_drop = 1'b1;
    issue(1'b0, 4'h4, 32'h0, 4'h0, 1'b1, 32'h0, 2'b10, 1'b1, 9);
    repeat (7) @(negedge clk);
    check("t5_arvalid_c8", 32'(ARVALID), 32'h1);
    @(negedge clk);
    check("t5_arvalid_c9", 32'(ARVALID), 32'h0);
    @(negedge clk);
    check("t5_cmd_ready_c10", 32'(CMD_READY), 32'h1);
    wait_done();
    allow_drop = 1'b0; ar_dly = 0;

    // Asynchronous reset while waiting for the write response
    b_dly = 3;
    issue(1'b1, 4'hC, 32'h1111_2222, 4'hF, 1'b0, 32'h0, 2'b00, 1'b0, 0);
    @(negedge clk);
    check("t6_bready_before_rst", 32'(BREADY), 32'h1);
    #2;
    rst = 1'b1;
    slave_rst = 1'b1;
    #1;
    check("t6_ctl_async", 32'({CMD_READY, RSP_VALID, RSP_TIMEOUT, AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'h0);
    check("t6_rsp_resp_async", 32'(RSP_RESP), 32'h0);
    check("t6_addr_async", 32'(AWADDR), 32'h0);
    check("t6_wdata_async", WDATA, 32'h0);
    repeat (2) @(negedge clk);
    check("t6_cmd_ready_in_rst", 32'(CMD_READY), 32'h0);
    rst = 1'b0;
    slave_rst = 1'b0;
    b_dly = 0;
    @(negedge clk);
    check("t6_cmd_ready_after_rst", 32'(CMD_READY), 32'h1);
    issue(1'b1, 4'h4, 32'h0000_00FF, 4'h1, 1'b1, 32'h0, 2'b00, 1'b0, 3);
    wait_done();
    check("t6_awaddr", 32'(aw_addr_seen), 32'h4);
    check("t6_wdata", w_data_seen, 32'h0000_00FF);

    repeat (3) @(negedge clk);
    check("valid_stability", 32'(stab_err), 32'h0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite initiator that converts simple register commands into AXI-Lite write and read transactions. It is used on the system side of the TRNG IP to configure and poll the AXI-Lite register slave from in-fabric logic: test harnesses, self-test sequencers and the boot-time configuration FSM. Responses, including slave error codes and a watchdog timeout, are returned on a one-cycle response strobe.

## Interface
- ADDR_W, default 4: AXI address width in bits.
- TIMEOUT, default 1024: watchdog limit in cycles per transaction; 0 disables the watchdog.
- AXI_M_ACLK  in  1  clock.
- AXI_M_ARESET  in  1  reset; one clock; reset is asynchronous and active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  byte address.
- CMD_WDATA  in  32  write data.
- CMD_WSTRB  in  4  write byte strobes.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_RDATA  out  32  read data; 0 for writes and timeouts.
- RSP_RESP  out  2  BRESP or RRESP as captured; 2'b10 on timeout.
- RSP_TIMEOUT  out  1  watchdog expired; valid with RSP_VALID.
- AXI_M_AWADDR  out  ADDR_W; AXI_M_AWPROT  out  3 (constant 3'b000); AXI_M_AWVALID  out  1; AXI_M_AWREADY  in  1.
- AXI_M_WDATA  out  32; AXI_M_WSTRB  out  4; AXI_M_WVALID  out  1; AXI_M_WREADY  in  1.
- AXI_M_BRESP  in  2; AXI_M_BVALID  in  1; AXI_M_BREADY  out  1.
- AXI_M_ARADDR  out  ADDR_W; AXI_M_ARPROT  out  3 (constant 3'b000); AXI_M_ARVALID  out  1; AXI_M_ARREADY  in  1.
- AXI_M_RDATA  in  32; AXI_M_RRESP  in  2; AXI_M_RVALID  in  1; AXI_M_RREADY  out  1.

## Operation
- States and their outputs:
  - IDLE: CMD_READY = 1.
  - WADDR: AWVALID and/or WVALID asserted.
  - WRESP: BREADY = 1.
  - RADDR: ARVALID = 1.
  - RDATA: RREADY = 1.
  - DONE: RSP_VALID = 1.
- CMD_READY is high only in IDLE. On accept, address, data, strobes and direction are registered. AXI address and data outputs are driven from these registers only and hold stable until their handshake.
- Write path:
  - IDLE goes to WADDR with AWVALID = WVALID = 1.
  - The aw_done and w_done flags are tracked independently. Each VALID drops the cycle after its own handshake. Both handshakes in the same cycle are allowed.
  - When both flags are set, go to WRESP.
  - On BVALID & BREADY, capture BRESP and go to DONE.
- Read path:
  - IDLE goes to RADDR with ARVALID = 1.
  - On ARREADY, go to RDATA.
  - On RVALID & RREADY, capture RDATA and RRESP, then go to DONE.
- DONE lasts exactly one cycle (RSP_VALID pulse), then returns to IDLE. A new command can be accepted in the IDLE cycle that follows. No back-pressure on the response.
- BVALID or RVALID arriving before BREADY or RREADY is asserted is held by the slave per AXI. The block never drops a VALID before its handshake, except on timeout.
- Watchdog:
  - A counter of width clog2(TIMEOUT+1) clears on command accept and increments every non-IDLE, non-DONE cycle.
  - When it reaches TIMEOUT: deassert all VALID and READY outputs and go to DONE with RSP_TIMEOUT = 1, RSP_RESP = 2'b10 and RSP_RDATA = 0.
  - Timeout is a fault-recovery path only; the interconnect must be reset afterwards.
  - The counter saturates and does not wrap.
- A completion handshake in the same cycle the counter reaches TIMEOUT counts as success; the handshake wins.
- Reset at any point:
  - All VALID, READY and RSP outputs go to 0 and the state goes to IDLE. CMD_READY goes to 0 during reset and to 1 on the first clock after reset release.
  - Registered address, data and strobes, RSP_RDATA and RSP_RESP reset to 0.
  - An in-flight transaction is discarded with no response.

## Timing
- Command accept happens at edge 0. AXI VALIDs are first visible in cycle 1 (registered; no combinational path from CMD_* to AXI_M_*).
- Write against a zero-wait slave (AW/W ready in cycle 1, BVALID in cycle 2):
  - BREADY in cycle 2, B handshake in cycle 2.
  - RSP_VALID in cycle 3.
  - Next accept possible in cycle 4.
- Read against a zero-wait slave (ARREADY in cycle 1, RVALID in cycle 2): RSP_VALID in cycle 3.
- Against the TRNG register slave (READY asserted one cycle after VALID, RVALID one cycle after ARREADY): write RSP_VALID in cycle 4, read RSP_VALID in cycle 4.
- Each additional slave wait cycle adds exactly one cycle of latency.

## Test plan
- Write 0x0000_0001 to 0x0 with WSTRB 4'hF against a zero-wait slave -> AWADDR = 0x0, WDATA = 0x0000_0001, RSP_VALID in cycle 3, RSP_RESP = 00, RSP_TIMEOUT = 0.
- Read 0x4 with the slave returning 0xDEAD_BEEF and RRESP 00 after 3 wait cycles -> ARVALID held steady through the waits, RSP_RDATA = 0xDEAD_BEEF, RSP_VALID in cycle 6.
- Write with WREADY 2 cycles before AWREADY -> WVALID drops after its own handshake, AWVALID stays high until AWREADY, exactly one B handshake, one RSP_VALID pulse.
- Read with slave RRESP = 2'b10 -> RSP_RESP = 10, RSP_TIMEOUT = 0.
- TIMEOUT = 8, slave never asserts ARREADY -> ARVALID drops after 8 cycles, RSP_VALID with RSP_TIMEOUT = 1, RSP_RESP = 10, RSP_RDATA = 0, then CMD_READY = 1.
- Assert AXI_M_ARESET while in WRESP -> all outputs 0 immediately (asynchronous), no RSP_VALID, a command after release completes normally.
